// File: rtl/prog_loader_if.sv
// Program-load bus: host-side start/byte stream in, instruction-memory write port out.
interface prog_loader_if;
   logic        start;
   logic [10:0] word_count;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wd;
   logic        busy;
   logic        done;
   logic        cpu_rst_n;

   // Host / byte source side
   modport master (
      output start, word_count, in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wd, busy, done, cpu_rst_n
   );

   // Loader side
   modport slave (
      input  start, word_count, in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wd, busy, done, cpu_rst_n
   );
endinterface

// File: rtl/prog_loader.sv
// Program loader: assembles a little-endian byte stream into 32-bit words and writes
// them to instruction memory, holding the CPU in reset until a full program is present.
module prog_loader #(
   parameter int unsigned DEPTH     = 1024,
   parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
   input logic          clk,
   input logic          rst,
   prog_loader_if.slave bus
);

   // word_count is 11 bits wide, so the clamp can never exceed 2047.
   localparam logic [10:0] MaxCount = (DEPTH > 32'd2047) ? 11'd2047 : 11'(DEPTH);

   typedef enum logic [1:0] {StIdle, StLoad, StWrite, StDone} state_e;

   state_e      state;
   state_e      state_next;
   logic [10:0] count;
   logic [10:0] word_idx;
   logic [1:0]  byte_idx;
   logic [23:0] byte_buf;   // bytes 0..2 of the word being assembled
   logic        accept;
   logic        last_word;

   // in_ready is registered as (state == StLoad), so the state compare is equivalent.
   assign accept    = (state == StLoad) && bus.in_valid;
   assign last_word = (word_idx == count - 11'd1);

   // Next-state decode
   always_comb begin
      state_next = state;
      unique case (state)
         StIdle, StDone: begin
            if (bus.start) begin
               state_next = (bus.word_count == 11'd0) ? StDone : StLoad;
            end
         end
         StLoad:  if (accept && (byte_idx == 2'd3)) state_next = StWrite;
         StWrite: state_next = last_word ? StDone : StLoad;
         default: state_next = StIdle;
      endcase
   end

   // State, datapath and registered outputs (outputs reflect the state being entered)
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= StIdle;
         count         <= '0;
         word_idx      <= '0;
         byte_idx      <= '0;
         byte_buf      <= '0;
         bus.in_ready  <= 1'b0;
         bus.mem_we    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wd    <= '0;
         bus.busy      <= 1'b0;
         bus.done      <= 1'b0;
         bus.cpu_rst_n <= 1'b0;
      end else begin
         state         <= state_next;
         bus.in_ready  <= (state_next == StLoad);
         bus.mem_we    <= (state_next == StWrite);
         bus.busy      <= (state_next == StLoad) || (state_next == StWrite);
         bus.done      <= (state_next == StDone);
         bus.cpu_rst_n <= (state_next == StDone);

         case (state)
            StIdle, StDone: begin
               if (bus.start && (bus.word_count != 11'd0)) begin
                  count    <= (bus.word_count > MaxCount) ? MaxCount : bus.word_count;
                  word_idx <= '0;
                  byte_idx <= '0;
               end
            end
            StLoad: begin
               if (accept) begin
                  byte_idx <= byte_idx + 2'd1;
                  case (byte_idx)
                     2'd0: byte_buf[7:0]   <= bus.in_data;
                     2'd1: byte_buf[15:8]  <= bus.in_data;
                     2'd2: byte_buf[23:16] <= bus.in_data;
                     default: begin
                        // Publish only on the final byte so mem_wd/mem_addr hold between writes.
                        bus.mem_wd   <= {bus.in_data, byte_buf};
                        bus.mem_addr <= BASE_ADDR + {19'd0, word_idx, 2'b00};
                     end
                  endcase
               end
            end
            StWrite: word_idx <= word_idx + 11'd1;
            default: ;
         endcase
      end
   end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter DEPTH, default 1024, instruction memory depth in 32-bit words.
REQ-002 Parameter BASE_ADDR, default 32'h00000000, byte address of the first word written.
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 start  input  1  single-cycle request to begin a program load.
REQ-006 word_count  input  11  number of words to load; sampled only when start is accepted.
REQ-007 in_valid  input  1  a program byte is present on in_data.
REQ-008 in_data  input  8  program byte stream, little-endian within each word.
REQ-009 in_ready  output  1  loader accepts a byte this cycle.
REQ-010 mem_we  output  1  instruction memory write strobe, one cycle per word.
REQ-011 mem_addr  output  32  byte address of the write, word-aligned (bits [1:0] always 0).
REQ-012 mem_wd  output  32  assembled instruction word.
REQ-013 busy  output  1  load in progress (state LOAD or WRITE).
REQ-014 done  output  1  last requested word has been written.
REQ-015 cpu_rst_n  output  1  active-low processor/instruction-fetch reset; low while no complete program is present.

Function
REQ-016 The FSM SHALL have exactly four states: IDLE, LOAD, WRITE and DONE.
REQ-017 In IDLE or DONE, start=1 with word_count!=0 SHALL latch count=min(word_count, DEPTH), clear the byte and word indices, and enter LOAD in the next cycle.
REQ-018 In IDLE or DONE, start=1 with word_count==0 SHALL enter DONE directly without any write.
REQ-019 start SHALL be ignored in LOAD and WRITE.
REQ-020 In LOAD, in_ready SHALL be 1, and a byte SHALL transfer only in a cycle where in_valid=1 and in_ready=1.
REQ-021 Byte k (k=0..3) of a word SHALL be stored in mem_wd[8k+7:8k].
REQ-022 in_valid=0 in LOAD SHALL stall the loader with no change to its state.
REQ-023 Acceptance of byte 3 SHALL move the FSM to WRITE in the next cycle.
REQ-024 In WRITE:
  - mem_we=1 for exactly that one cycle;
  - in_ready=0;
  - mem_addr=BASE_ADDR+4*word_idx;
  - mem_wd=the assembled word.
REQ-025 Latency: if byte 3 is accepted in cycle N, mem_we SHALL be 1 in cycle N+1.
REQ-026 Peak throughput SHALL be one word per 5 cycles.
REQ-027 After WRITE, word_idx SHALL increment.
REQ-028 After WRITE, the next state SHALL be DONE if the written word was word count-1, otherwise LOAD.
REQ-029 In DONE: done=1, cpu_rst_n=1, in_ready=0 and mem_we=0.
REQ-030 On a restart from DONE, done SHALL clear and cpu_rst_n SHALL drop to 0 in the cycle after start.
REQ-031 word_count>DEPTH SHALL be clamped to DEPTH, so the last write address is BASE_ADDR+4*(DEPTH-1) with no address wrap.
REQ-032 All outputs SHALL be registered or decoded only from state, and SHALL be glitch-free with respect to the inputs.
REQ-033 mem_wd and mem_addr SHALL hold their last values outside WRITE.

Reset
REQ-034 rst=1 SHALL force, by the next edge: state=IDLE, in_ready=0, mem_we=0, mem_addr=0, mem_wd=0, busy=0, done=0, cpu_rst_n=0, and all indices=0.
REQ-035 rst asserted during LOAD or WRITE SHALL discard any partial word, perform no write in the following cycle, and require a new start.
REQ-036 rst SHALL take priority over start and in_valid in the same cycle.

Verification
REQ-037 Single word: start, word_count=1, bytes 93,02,50,00 streamed back-to-back -> one mem_we pulse with mem_addr=0 and mem_wd=32'h00500293, followed by done=1 and cpu_rst_n=1.
REQ-038 Six words streamed with random in_valid gaps -> mem_we pulses at addresses 0,4,...,20 carrying the words in order, no extra writes, and bytes accepted only when in_ready=1.
REQ-039 start with word_count=0 -> DONE within 1 cycle, no mem_we, done=1.
REQ-040 word_count=2000 -> exactly 1024 writes, last mem_addr=32'h00000FFC, then done.
REQ-041 rst asserted after byte 2 of word 3 -> all outputs at reset values next cycle, no write of word 3, cpu_rst_n=0.
REQ-042 start asserted during LOAD is ignored; start in DONE reloads, with done=0 and cpu_rst_n=0 in the cycle after start.
